img_row_loader: RTL and testbench



---
 rtl/sift_img_pkg.sv | 19 +
 rtl/img_row_packer.sv | 52 +++++
 rtl/img_row_loader.sv | 119 +++++++++++
 tb/tb_img_row_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_img_pkg.sv
// Shared constants and state type for the SIFT image front end.
// Optional feature macro used by img_row_loader: IMG_ROW_LOADER_CHECKSUM_EN.
package sift_img_pkg;

  localparam int unsigned IMG_W  = 640;
  localparam int unsigned IMG_H  = 480;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned ROW_W  = IMG_W * PIX_W;
  localparam int unsigned CSUM_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } load_state_e;

endpackage

// File: rtl/img_row_packer.sv
// Row packer: inserts each accepted pixel into its byte lane of row_reg and
// flags the pixel that completes the row. Column 0 lands in the low lane.
module img_row_packer
  import sift_img_pkg::*;
#(
  parameter int unsigned IMG_W = sift_img_pkg::IMG_W,
  parameter int unsigned PIX_W = sift_img_pkg::PIX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   pix_we,
  input  logic [PIX_W-1:0]       pix_data,
  output logic                   row_full,
  output logic [IMG_W*PIX_W-1:0] row_data
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [COL_W-1:0]       col_cnt;
  logic [IMG_W*PIX_W-1:0] row_reg;
  logic                   last_col;

  assign last_col = (col_cnt == COL_W'(IMG_W - 1));
  assign row_full = pix_we & last_col;
  assign row_data = row_reg;

  // Column counter: advances per accepted pixel, wraps after the last column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
    end else if (clear) begin
      col_cnt <= '0;
    end else if (pix_we) begin
      col_cnt <= last_col ? '0 : col_cnt + COL_W'(1);
    end
  end

  // Byte-lane insert; lanes are never cleared since every lane is rewritten per row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg <= '0;
    end else if (pix_we) begin
      for (int unsigned c = 0; c < IMG_W; c++) begin
        if (col_cnt == COL_W'(c)) begin
          row_reg[c*PIX_W +: PIX_W] <= pix_data;
        end
      end
    end
  end

endmodule

// File: rtl/img_row_loader.sv
// Frame loader: packs a raster pixel stream into rows and writes each row to
// the original-image SRAM, pulsing done after the last row.
// Optional macro IMG_ROW_LOADER_CHECKSUM_EN adds a 24-bit frame pixel sum.
module img_row_loader
  import sift_img_pkg::*;
#(
  parameter int unsigned IMG_W  = sift_img_pkg::IMG_W,
  parameter int unsigned IMG_H  = sift_img_pkg::IMG_H,
  parameter int unsigned PIX_W  = sift_img_pkg::PIX_W,
  parameter int unsigned ADDR_W = sift_img_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic                   pix_valid,
  input  logic [PIX_W-1:0]       pix_data,
  output logic                   pix_ready,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [IMG_W*PIX_W-1:0] mem_din,
  output logic                   busy,
  output logic                   done
`ifdef IMG_ROW_LOADER_CHECKSUM_EN
  ,
  output logic [CSUM_W-1:0]      checksum
`endif
);

  load_state_e       state, state_nxt;
  logic [ADDR_W-1:0] row_cnt;
  logic              in_fill;
  logic              accept;
  logic              start_ok;
  logic              row_full;
  logic              last_row;

  // Acceptance is decoded straight from state so the handshake does not loop
  // back through the output decode below.
  assign in_fill  = (state == FILL);
  assign accept   = pix_valid & in_fill;
  assign start_ok = (state == IDLE) & load_start;
  assign last_row = (row_cnt == ADDR_W'(IMG_H - 1));
  assign mem_addr = row_cnt;

  img_row_packer #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .pix_we   (accept),
    .pix_data (pix_data),
    .row_full (row_full),
    .row_data (mem_din)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (load_start) state_nxt = FILL;
      end
      FILL: begin
        pix_ready = 1'b1;
        if (row_full) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        state_nxt = last_row ? DONE : FILL;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row address: cleared on a new frame, advanced after each non-final write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
    end else if (start_ok) begin
      row_cnt <= '0;
    end else if ((state == WRITE) && !last_row) begin
      row_cnt <= row_cnt + ADDR_W'(1);
    end
  end

`ifdef IMG_ROW_LOADER_CHECKSUM_EN
  // Modular sum of accepted pixels; holds after done until the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + CSUM_W'(pix_data);
    end
  end
`endif

endmodule

// File: tb/tb_img_row_loader.sv
// Self-checking bench for img_row_loader on a reduced frame (16x6 pixels).
// Checks the checksum output too when IMG_ROW_LOADER_CHECKSUM_EN is defined.
module tb_img_row_loader;

  localparam int unsigned W   = 16;
  localparam int unsigned H   = 6;
  localparam int unsigned P   = 8;
  localparam int unsigned A   = 3;
  localparam int unsigned ROW = W * P;

  logic           clk        = 1'b0;
  logic           rst_n      = 1'b0;
  logic           load_start = 1'b0;
  logic           pix_valid  = 1'b0;
  logic [P-1:0]   pix_data   = '0;
  logic           pix_ready;
  logic           mem_we;
  logic [A-1:0]   mem_addr;
  logic [ROW-1:0] mem_din;
  logic           busy;
  logic           done;
`ifdef IMG_ROW_LOADER_CHECKSUM_EN
  logic [23:0]    checksum;
`endif

  img_row_loader #(
    .IMG_W  (W),
    .IMG_H  (H),
    .PIX_W  (P),
    .ADDR_W (A)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .busy       (busy),
    .done       (done)
`ifdef IMG_ROW_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [A-1:0]   addr;
    logic [ROW-1:0] din;
    int             cyc;
  } wr_t;
  wr_t sb[$];
  wr_t mon_e;

  // Reference model of the row being assembled.
  logic [P-1:0] mrow_buf [W];
  int           mcol = 0;
  int           mrow = 0;
  int           last_acc_cyc = 0;
  logic [23:0]  msum = '0;

  typedef struct {
    logic rst_n;
    logic ls;
    logic pv;
    logic e_rdy;
    logic e_busy;
    logic e_we;
    logic e_done;
  } vec_t;
  vec_t vt [7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [P-1:0] pix_val(input int mode, input int col);
    case (mode)
      0:       return P'(col);
      1:       return 8'hA5;
      2:       return P'($urandom);
      default: return 8'hFF;
    endcase
  endfunction

  // Write monitor: every SRAM write must match the oldest completed model row.
  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && mem_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual write to addr %0d required none", mem_addr);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
        check("wr_latency", 64'(cyc), 64'(mon_e.cyc + 1));
        check("ready_in_write", 64'(pix_ready), 64'(0));
        checks++;
        if (mem_din !== mon_e.din) begin
          errors++;
          $display("FAIL wr_din: actual %h required %h", mem_din, mon_e.din);
        end
      end
    end
  end

  task automatic stream(input int n, input int mode, input int duty, input int ls_at);
    int sent = 0;
    int budget = n * 30 + 50;
    logic [P-1:0] v;
    logic [ROW-1:0] din;
    while (sent < n && budget > 0) begin
      @(negedge clk);
      budget--;
      v = pix_val(mode, mcol);
      load_start = (sent == ls_at);
      pix_valid  = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      pix_data   = pix_valid ? v : P'($urandom);
      if (pix_valid && pix_ready) begin
        mrow_buf[mcol] = v;
        msum = msum + 24'(v);
        last_acc_cyc = cyc;
        mcol++;
        sent++;
        if (mcol == W) begin
          for (int c = 0; c < W; c++) din[c*P +: P] = mrow_buf[c];
          sb.push_back('{addr: A'(mrow), din: din, cyc: cyc});
          mcol = 0;
          mrow++;
        end
      end
    end
    check("stream_pixels_sent", 64'(sent), 64'(n));
  endtask

  task automatic start_frame();
    @(negedge clk);
    load_start = 1'b1;
    pix_valid  = 1'b0;
    #1;
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_ready", 64'(pix_ready), 64'(0));
    @(negedge clk);
    load_start = 1'b0;
    check("start_busy", 64'(busy), 64'(1));
    check("start_ready", 64'(pix_ready), 64'(1));
`ifdef IMG_ROW_LOADER_CHECKSUM_EN
    check("checksum_cleared", 64'(checksum), 64'(0));
`endif
    mrow = 0;
    mcol = 0;
    msum = '0;
  endtask

  task automatic wait_done();
    int w = 0;
    bit seen = 1'b0;
    while (!seen && w < 10) begin
      @(negedge clk);
      w++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'(1));
    if (seen) begin
      check("done_latency", 64'(cyc), 64'(last_acc_cyc + 2));
      check("busy_at_done", 64'(busy), 64'(1));
`ifdef IMG_ROW_LOADER_CHECKSUM_EN
      check("checksum_at_done", 64'(checksum), 64'(msum));
`endif
      // load_start coinciding with done must be ignored.
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      check("busy_after_done", 64'(busy), 64'(0));
      check("done_one_cycle", 64'(done), 64'(0));
      check("no_restart_from_done", 64'(pix_ready), 64'(0));
    end
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst_n      = vt[i].rst_n;
      load_start = vt[i].ls;
      pix_valid  = vt[i].pv;
      pix_data   = 8'h5A;
      #1;
      check($sformatf("vec%0d_ready", i), 64'(pix_ready), 64'(vt[i].e_rdy));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
      check($sformatf("vec%0d_we", i), 64'(mem_we), 64'(vt[i].e_we));
      check($sformatf("vec%0d_done", i), 64'(done), 64'(vt[i].e_done));
      check($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(0));
`ifdef IMG_ROW_LOADER_CHECKSUM_EN
      check($sformatf("vec%0d_checksum", i), 64'(checksum), 64'(0));
`endif
    end
    mrow = 0;
    mcol = 0;
    msum = '0;

    // Frame 1: column-index pattern, continuous valid.
    stream(W * H, 0, 100, -1);
    wait_done();

    // Frame 2: constant 0xA5 with a stray load_start at row 3 col 7.
    start_frame();
    stream(W * H, 1, 100, 3 * W + 7);
    wait_done();

    // Frame 3: random data with ~50% valid duty.
    start_frame();
    stream(W * H, 2, 50, -1);
    wait_done();

    // Frame 4: reset asserted during the write of row 2.
    start_frame();
    stream(W * 3, 2, 100, -1);
    @(negedge clk);
    check("we_before_reset", 64'(mem_we), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_we", 64'(mem_we), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_ready", 64'(pix_ready), 64'(0));
    check("reset_addr", 64'(mem_addr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pix_valid = 1'b0;
    check("sb_empty_after_reset", 64'(sb.size()), 64'(0));

    // Frame 5: all 0xFF after the aborted frame, starting again at row 0.
    start_frame();
    stream(W * H, 3, 100, -1);
    wait_done();

    repeat (4) @(negedge clk);
    check("done_pulse_count", 64'(done_cnt), 64'(4));
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
